// File: rtl/rrc_pkg.sv
// rtl/rrc_pkg.sv - shared defaults, default RRC coefficients and helpers for the symmetric FIR
package rrc_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < value) r = i + 1;
        return r;
    endfunction

    localparam int RRC_DW    = 7;
    localparam int RRC_CW    = 9;
    localparam int RRC_NTAPS = 33;
    localparam int RRC_NUNIQ = (RRC_NTAPS + 1) / 2;

    // Unique taps of the 33-tap RRC, index 0 = outermost, 16 = centre.
    localparam logic [0:RRC_NUNIQ-1][8:0] RRC_DEFAULT_COEF = {
        9'h000, 9'h1FF, 9'h001, 9'h000, 9'h1FF, 9'h002, 9'h000, 9'h1FE, 9'h002,
        9'h000, 9'h1FA, 9'h008, 9'h00A, 9'h1E4, 9'h1F2, 9'h06F, 9'h0C4
    };

    // Centre-aligned lookup; taps beyond the stored set read as zero.
    function automatic logic signed [8:0] rrc_default_coef(input int k, input int nuniq);
        int idx;
        idx = k + RRC_NUNIQ - nuniq;
        if (idx < 0 || idx >= RRC_NUNIQ) return '0;
        return RRC_DEFAULT_COEF[idx];
    endfunction

endpackage

// File: rtl/rrc_sum_tree.sv
// rtl/rrc_sum_tree.sv - registered group partial sums followed by a combinational final add
module rrc_sum_tree
    import rrc_pkg::*;
#(
    parameter int N     = 17,
    parameter int GROUP = 8,
    parameter int IW    = 17,
    parameter int OW    = 22
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic signed [IW-1:0] i_prod [N],
    output logic signed [OW-1:0] o_total
);
    localparam int NGRP = (N + GROUP - 1) / GROUP;
    localparam int SW   = IW + clog2(GROUP);

    logic signed [SW-1:0] w_part [NGRP];
    logic signed [SW-1:0] r_part [NGRP];

    always_comb begin
        logic signed [SW-1:0] v_acc;
        for (int g = 0; g < NGRP; g++) begin
            v_acc = '0;
            for (int k = 0; k < N; k++)
                if (k / GROUP == g) v_acc = v_acc + SW'(i_prod[k]);
            w_part[g] = v_acc;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int g = 0; g < NGRP; g++) r_part[g] <= '0;
        end else begin
            for (int g = 0; g < NGRP; g++) r_part[g] <= w_part[g];
        end
    end

    always_comb begin
        o_total = '0;
        for (int g = 0; g < NGRP; g++) o_total = o_total + OW'(r_part[g]);
    end

endmodule

// File: rtl/rrc_fir_sym_prog.sv
// rtl/rrc_fir_sym_prog.sv - streaming symmetric RRC FIR, folded pre-add, double-buffered coefficients
module rrc_fir_sym_prog
    import rrc_pkg::*;
#(
    parameter int DW       = RRC_DW,
    parameter int CW       = RRC_CW,
    parameter int NTAPS    = RRC_NTAPS,
    parameter int SHIFT    = 8,
    parameter int ROUND_EN = 1,
    parameter int GROUP    = 8
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              in_valid,
    input  logic signed [DW-1:0]              data_in,
    input  logic                              coef_we,
    input  logic [clog2((NTAPS+1)/2)-1:0]     coef_addr,
    input  logic signed [CW-1:0]              coef_data,
    input  logic                              coef_swap,
    output logic                              out_valid,
    output logic signed [DW-1:0]              data_out,
    output logic                              out_sat
);
    localparam int NUNIQ = (NTAPS + 1) / 2;
    localparam int PW    = DW + 1;
    localparam int MW    = DW + CW + 1;
    localparam int TW    = MW + clog2(NUNIQ);
    localparam logic signed [TW:0] RND  = (ROUND_EN != 0 && SHIFT > 0) ? (TW+1)'(1) <<< (SHIFT - 1) : '0;
    localparam logic signed [TW:0] OMAX = (TW+1)'((1 << (DW - 1)) - 1);
    localparam logic signed [TW:0] OMIN = ~OMAX;

    logic signed [DW-1:0] r_x      [NTAPS];
    logic signed [CW-1:0] r_shadow [NUNIQ];
    logic signed [CW-1:0] r_active [NUNIQ];
    logic signed [PW-1:0] r_pre    [NUNIQ];
    logic signed [MW-1:0] r_prod   [NUNIQ];
    logic [3:0]           r_vld;

    logic signed [TW-1:0] w_total;
    logic signed [TW:0]   w_rnd;
    logic signed [TW:0]   w_shr;
    logic                 w_hi;
    logic                 w_lo;

    rrc_sum_tree #(
        .N     (NUNIQ),
        .GROUP (GROUP),
        .IW    (MW),
        .OW    (TW)
    ) u_sum (
        .clk     (clk),
        .rstn    (rstn),
        .i_prod  (r_prod),
        .o_total (w_total)
    );

    // One extra bit keeps the rounding add from wrapping at full scale.
    assign w_rnd = (TW+1)'(w_total) + RND;
    assign w_shr = w_rnd >>> SHIFT;
    assign w_hi  = (w_shr > OMAX);
    assign w_lo  = (w_shr < OMIN);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NTAPS; k++) r_x[k] <= '0;
            for (int k = 0; k < NUNIQ; k++) begin
                r_shadow[k] <= '0;
                r_active[k] <= CW'(rrc_default_coef(k, NUNIQ));
                r_pre[k]    <= '0;
                r_prod[k]   <= '0;
            end
            r_vld     <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (in_valid) begin
                r_x[0] <= data_in;
                for (int k = 1; k < NTAPS; k++) r_x[k] <= r_x[k-1];
            end
            for (int k = 0; k < NUNIQ; k++) begin
                r_pre[k]  <= (k == NUNIQ - 1) ? PW'(r_x[k]) : PW'(r_x[k]) + PW'(r_x[NTAPS-1-k]);
                r_prod[k] <= MW'(r_pre[k]) * MW'(r_active[k]);
            end
            // Swap copies the shadow as it stood before any same-cycle write.
            if (coef_swap) r_active <= r_shadow;
            if (coef_we && int'(coef_addr) < NUNIQ) r_shadow[coef_addr] <= coef_data;
            r_vld     <= {r_vld[2:0], in_valid};
            out_valid <= r_vld[3];
            if (r_vld[3]) begin
                data_out <= w_hi ? DW'(OMAX) : (w_lo ? DW'(OMIN) : DW'(w_shr));
                out_sat  <= w_hi | w_lo;
            end
        end
    end

endmodule

// File: tb/tb_rrc_fir_sym_prog.sv
// tb/tb_rrc_fir_sym_prog.sv - directed table-driven bench for rrc_fir_sym_prog
module tb_rrc_fir_sym_prog;
    logic              clk       = 1'b0;
    logic              rstn      = 1'b0;
    logic              in_valid  = 1'b0;
    logic signed [6:0] data_in   = '0;
    logic              coef_we   = 1'b0;
    logic [4:0]        coef_addr = '0;
    logic signed [8:0] coef_data = '0;
    logic              coef_swap = 1'b0;
    logic              out_valid;
    logic signed [6:0] data_out;
    logic              out_sat;

    typedef struct {
        int   din;
        int   dout;
        logic sat;
    } vec_t;

    vec_t tab [34];
    int   imp63 [34] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                         -1, 2, 2, -7, -3, 27, 48, 27, -3, -7, 2, 2, -1,
                         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int   n_tests = 0;
    int   n_fail  = 0;
    logic signed [6:0] q_data [$];
    logic              q_sat  [$];
    logic [4:0]        hist;

    always #5 clk = ~clk;

    rrc_fir_sym_prog dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .coef_swap (coef_swap),
        .out_valid (out_valid),
        .data_out  (data_out),
        .out_sat   (out_sat)
    );

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) hist <= '0;
        else       hist <= {hist[3:0], in_valid};
    end

    always @(negedge clk) begin
        if (rstn) begin
            chk("latency", out_valid, hist[4]);
            if (out_valid) begin
                q_data.push_back(data_out);
                q_sat.push_back(out_sat);
            end
        end
    end

    task automatic step(input logic v, input int d);
        in_valid = v;
        data_in  = 7'(d);
        @(negedge clk);
    endtask

    task automatic wr(input int a, input int d, input logic sw);
        coef_we   = 1'b1;
        coef_addr = 5'(a);
        coef_data = 9'(d);
        coef_swap = sw;
        @(negedge clk);
        coef_we   = 1'b0;
        coef_swap = 1'b0;
    endtask

    task automatic swap_bank();
        coef_swap = 1'b1;
        @(negedge clk);
        coef_swap = 1'b0;
    endtask

    function automatic void fill_imp63();
        for (int i = 0; i < 34; i++) begin
            tab[i].din  = (i == 0) ? 63 : 0;
            tab[i].dout = imp63[i];
            tab[i].sat  = 1'b0;
        end
    endfunction

    function automatic void fill_centre(input int amp, input int cval);
        for (int i = 0; i < 34; i++) begin
            tab[i].din  = (i == 0) ? amp : 0;
            tab[i].dout = (i == 16) ? cval : 0;
            tab[i].sat  = 1'b0;
        end
    endfunction

    task automatic apply_tab(input string nm, input int n, input int gap);
        q_data.delete();
        q_sat.delete();
        for (int i = 0; i < n; i++) begin
            step(1'b1, tab[i].din);
            repeat (gap) step(1'b0, 17);
        end
        repeat (6) step(1'b0, 0);
        chk($sformatf("%s_count", nm), q_data.size(), n);
        for (int i = 0; i < n && i < q_data.size(); i++) begin
            chk($sformatf("%s_data[%0d]", nm, i), q_data[i], tab[i].dout);
            chk($sformatf("%s_sat[%0d]", nm, i), q_sat[i], tab[i].sat);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_out_sat", out_sat, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        fill_imp63();
        apply_tab("impulse", 34, 0);

        q_data.delete();
        q_sat.delete();
        repeat (40) step(1'b1, 63);
        repeat (6) step(1'b0, 0);
        chk("dc_pos_count", q_data.size(), 40);
        if (q_data.size() > 0) begin
            chk("dc_pos_data", q_data[$], 63);
            chk("dc_pos_sat", q_sat[$], 1);
        end
        q_data.delete();
        q_sat.delete();
        repeat (40) step(1'b1, -64);
        repeat (6) step(1'b0, 0);
        if (q_data.size() > 0) begin
            chk("dc_neg_data", q_data[$], -64);
            chk("dc_neg_sat", q_sat[$], 1);
        end
        repeat (34) step(1'b1, 0);
        repeat (6) step(1'b0, 0);
        chk("dc_flush_data", data_out, 0);
        chk("dc_flush_sat", out_sat, 0);

        fill_imp63();
        apply_tab("gapped", 34, 2);

        for (int a = 0; a < 17; a++) wr(a, (a == 16) ? 128 : 0, 1'b0);
        wr(31, 100, 1'b0);
        fill_imp63();
        apply_tab("noswap", 34, 0);
        swap_bank();
        repeat (2) step(1'b0, 0);
        fill_centre(32, 16);
        apply_tab("reload", 34, 0);

        wr(16, 64, 1'b1);
        repeat (2) step(1'b0, 0);
        fill_centre(32, 16);
        apply_tab("swapwr_old", 34, 0);
        swap_bank();
        repeat (2) step(1'b0, 0);
        fill_centre(32, 8);
        apply_tab("swapwr_new", 34, 0);

        step(1'b1, 63);
        repeat (16) step(1'b1, 0);
        repeat (4) step(1'b0, 0);
        repeat (2) step(1'b1, 0);
        chk("mid_pre_data", data_out, 16);
        in_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_data_out", data_out, 0);
        chk("mid_rst_out_sat", out_sat, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_out_valid", out_valid, 0);
        fill_imp63();
        apply_tab("post_reset", 34, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
